// File: rtl/vga_text_timing.sv
// vga_text_timing
//   VGA 640x480@60 timing generator with a 32x22 text-cell address sequencer.
//   The h/v counters feed a registered stage that produces text-cell indices
//   (char_index, glyph_row, glyph_col, in_text) and raw sync/blank. Sync and
//   blank then pass through a PIPE_DLY-deep delay line, so they line up with
//   the downstream character fetch / font ROM latency.
//
//   Optional feature: define VGA_TEXT_BLINK_EN to build the frame counter that
//   drives blink; otherwise blink is tied to 0.
//
// Ports
//   clk          pixel-domain clock
//   reset        asynchronous, active-low reset
//   en           pixel enable; every register advances only when en=1
//   hsync/vsync  active-low syncs, delayed by PIPE_DLY enabled cycles
//   blank        active-low DAC blank (1 = visible pixel), delayed like sync
//   sync         DAC composite sync, constant 0
//   frame_start  one-enabled-cycle pulse when the counters wrap to (0,0)
//   in_text      pixel lies inside the text window
//   char_index   row*TXT_COLS+col, 0 outside the window
//   glyph_row    pixel row inside the 16x16 cell, 0 outside the window
//   glyph_col    pixel column inside the 16x16 cell, 0 outside the window
//   blink        blink phase, toggles every 32 frames
module vga_text_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TXT_COLS = 32,
  parameter int TXT_ROWS = 22,
  parameter int TXT_X0   = 64,
  parameter int TXT_Y0   = 64,
  parameter int PIPE_DLY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       sync,
  output logic       frame_start,
  output logic       in_text,
  output logic [9:0] char_index,
  output logic [3:0] glyph_row,
  output logic [3:0] glyph_col,
  output logic       blink
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int COL_SH   = $clog2(TXT_COLS);
  localparam int X_END    = TXT_X0 + 16 * TXT_COLS;
  localparam int Y_END    = TXT_Y0 + 16 * TXT_ROWS;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int PW       = PIPE_DLY + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  // Cleared by reset so the post-reset (0,0) is not reported as a frame start.
  logic          r_armed;

  logic [31:0]   w_h32;
  logic [31:0]   w_v32;
  logic [HW-1:0] w_hx;
  logic [VW-1:0] w_vy;
  logic          w_in_text;
  logic [9:0]    w_char;
  logic [3:0]    w_grow;
  logic [3:0]    w_gcol;
  logic          w_hs;
  logic          w_vs;
  logic          w_de;
  logic          w_fs;

  logic          r_in_text;
  logic [9:0]    r_char;
  logic [3:0]    r_grow;
  logic [3:0]    r_gcol;
  logic          r_fs;
  // Index 0 is the stage-1 register; index PIPE_DLY drives the outputs.
  logic [PW-1:0] r_hs_p;
  logic [PW-1:0] r_vs_p;
  logic [PW-1:0] r_de_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_armed <= 1'b0;
    end else if (en) begin
      r_armed <= 1'b1;
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  always_comb begin
    w_h32     = 32'(r_h);
    w_v32     = 32'(r_v);
    w_hx      = r_h - HW'(TXT_X0);
    w_vy      = r_v - VW'(TXT_Y0);
    w_in_text = (w_h32 >= TXT_X0) && (w_h32 < X_END) &&
                (w_v32 >= TXT_Y0) && (w_v32 < Y_END);
    w_char    = '0;
    w_grow    = '0;
    w_gcol    = '0;
    if (w_in_text) begin
      // TXT_COLS is a power of two, so row*TXT_COLS is a shift.
      w_char = (10'(w_vy >> 4) << COL_SH) + 10'(w_hx >> 4);
      w_grow = w_vy[3:0];
      w_gcol = w_hx[3:0];
    end
    w_hs = !((w_h32 >= HS_START) && (w_h32 < HS_END));
    w_vs = !((w_v32 >= VS_START) && (w_v32 < VS_END));
    w_de = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    w_fs = r_armed && (r_h == '0) && (r_v == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_text <= 1'b0;
      r_char    <= '0;
      r_grow    <= '0;
      r_gcol    <= '0;
      r_fs      <= 1'b0;
      r_hs_p    <= '1;
      r_vs_p    <= '1;
      r_de_p    <= '0;
    end else if (en) begin
      r_in_text <= w_in_text;
      r_char    <= w_char;
      r_grow    <= w_grow;
      r_gcol    <= w_gcol;
      r_fs      <= w_fs;
      r_hs_p    <= PW'({r_hs_p, w_hs});
      r_vs_p    <= PW'({r_vs_p, w_vs});
      r_de_p    <= PW'({r_de_p, w_de});
    end
  end

  assign hsync       = r_hs_p[PIPE_DLY];
  assign vsync       = r_vs_p[PIPE_DLY];
  assign blank       = r_de_p[PIPE_DLY];
  assign sync        = 1'b0;
  assign frame_start = r_fs;
  assign in_text     = r_in_text;
  assign char_index  = r_char;
  assign glyph_row   = r_grow;
  assign glyph_col   = r_gcol;

`ifdef VGA_TEXT_BLINK_EN
  // Counts frames modulo 32; the phase flips as the count wraps, so blink is
  // low for frames 0..31 and high for 32..63. It updates on the same edge
  // that raises frame_start.
  logic [4:0] r_frame_cnt;
  logic       r_blink;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (en && w_fs) begin
      r_frame_cnt <= r_frame_cnt + 5'd1;
      if (r_frame_cnt == 5'd31) r_blink <= ~r_blink;
    end
  end

  assign blink = r_blink;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_text_timing.sv
module tb_vga_text_timing;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    int cols, rows, x0, y0, dly;
  } geo_t;

  // Table record: instance (0 = full 640x480, 1 = small), enabled-cycle count
  // since reset release, and the expected text/hsync outputs at that point.
  typedef struct {
    int   inst;
    int   k;
    logic it;
    int   ci;
    int   gr;
    int   gc;
    logic hs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  logic       f_hs, f_vs, f_bl, f_sy, f_fs, f_it, f_bk;
  logic [9:0] f_ci;
  logic [3:0] f_gr, f_gc;
  logic       s_hs, s_vs, s_bl, s_sy, s_fs, s_it, s_bk;
  logic [9:0] s_ci;
  logic [3:0] s_gr, s_gc;
  logic       t_hs, t_vs, t_bl, t_sy, t_fs, t_it, t_bk;
  logic [9:0] t_ci;
  logic [3:0] t_gr, t_gc;

  vga_text_timing dut_full (
    .clk(clk), .reset(reset), .en(en),
    .hsync(f_hs), .vsync(f_vs), .blank(f_bl), .sync(f_sy),
    .frame_start(f_fs), .in_text(f_it), .char_index(f_ci),
    .glyph_row(f_gr), .glyph_col(f_gc), .blink(f_bk)
  );

  vga_text_timing #(
    .H_ACTIVE(96), .H_FP(8), .H_SYNC(12), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .TXT_COLS(4), .TXT_ROWS(2), .TXT_X0(16), .TXT_Y0(4), .PIPE_DLY(1)
  ) dut_small (
    .clk(clk), .reset(reset), .en(en),
    .hsync(s_hs), .vsync(s_vs), .blank(s_bl), .sync(s_sy),
    .frame_start(s_fs), .in_text(s_it), .char_index(s_ci),
    .glyph_row(s_gr), .glyph_col(s_gc), .blink(s_bk)
  );

  vga_text_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .TXT_COLS(1), .TXT_ROWS(1), .TXT_X0(0), .TXT_Y0(0), .PIPE_DLY(0)
  ) dut_tiny (
    .clk(clk), .reset(reset), .en(en),
    .hsync(t_hs), .vsync(t_vs), .blank(t_bl), .sync(t_sy),
    .frame_start(t_fs), .in_text(t_it), .char_index(t_ci),
    .glyph_row(t_gr), .glyph_col(t_gc), .blink(t_bk)
  );

  geo_t g_full, g_small, g_tiny;
  int   n_checks = 0;
  int   n_fail = 0;
  int   k = 0;
  int   first_fall = -1;
  int   blink_rise = -1;
  int   small_fs_cnt = 0;
  logic prev_f_hs = 1'b1;
  logic prev_t_bk = 1'b0;

  // Expected outputs after k enabled edges since reset release, derived from
  // the frame geometry: the index stage shows counter state k-1, the sync
  // stage shows state k-1-dly, and states are numbered in raster order.
  function automatic logic [24:0] model(input geo_t g, input int kk);
    int   ht, vt, fr, s, t, h, v, ci, gr, gc;
    logic hs, vs, de, fs, it, bl;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    fr = ht * vt;
    hs = 1'b1; vs = 1'b1; de = 1'b0; fs = 1'b0; it = 1'b0; bl = 1'b0;
    ci = 0; gr = 0; gc = 0;
    if (kk >= 1) begin
      s  = kk - 1;
      h  = s % ht;
      v  = (s / ht) % vt;
      it = (h >= g.x0) && (h < g.x0 + 16 * g.cols) &&
           (v >= g.y0) && (v < g.y0 + 16 * g.rows);
      if (it) begin
        ci = ((v - g.y0) / 16) * g.cols + (h - g.x0) / 16;
        gr = (v - g.y0) % 16;
        gc = (h - g.x0) % 16;
      end
      fs = (s > 0) && (s % fr == 0);
`ifdef VGA_TEXT_BLINK_EN
      bl = (((s / fr) / 32) % 2) == 1;
`endif
    end
    t = kk - 1 - g.dly;
    if (t >= 0) begin
      h  = t % ht;
      v  = (t / ht) % vt;
      hs = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hs));
      vs = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vs));
      de = (h < g.ha) && (v < g.va);
    end
    return {hs, vs, de, 1'b0, fs, it, 10'(ci), 4'(gr), 4'(gc), bl};
  endfunction

  task automatic cmp(input string name, input logic [24:0] got, input logic [24:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  task automatic check_all();
    cmp("full", {f_hs, f_vs, f_bl, f_sy, f_fs, f_it, f_ci, f_gr, f_gc, f_bk}, model(g_full, k));
    cmp("small", {s_hs, s_vs, s_bl, s_sy, s_fs, s_it, s_ci, s_gr, s_gc, s_bk}, model(g_small, k));
    cmp("tiny", {t_hs, t_vs, t_bl, t_sy, t_fs, t_it, t_ci, t_gr, t_gc, t_bk}, model(g_tiny, k));
  endtask

  task automatic cyc(input logic e);
    en = e;
    @(posedge clk);
    if (e && reset) k++;
    @(negedge clk);
    check_all();
    if (prev_f_hs && !f_hs && first_fall < 0) first_fall = k;
    if (!prev_t_bk && t_bk && blink_rise < 0) blink_rise = k;
    prev_f_hs = f_hs;
    prev_t_bk = t_bk;
  endtask

  vec_t vecs[18];

  initial begin
    logic [8:0]  got_v, exp_v;
    int          blink_exp;

    g_full  = '{640, 16, 96, 48, 480, 10, 2, 33, 32, 22, 64, 64, 2};
    g_small = '{96, 8, 12, 4, 40, 2, 2, 3, 4, 2, 16, 4, 1};
    g_tiny  = '{16, 2, 4, 2, 8, 1, 1, 1, 1, 1, 0, 0, 0};

    vecs[0]  = '{1, 105,   1'b0, 0, 0,  0,  1'b1};
    vecs[1]  = '{1, 106,   1'b0, 0, 0,  0,  1'b0};
    vecs[2]  = '{1, 117,   1'b0, 0, 0,  0,  1'b0};
    vecs[3]  = '{1, 118,   1'b0, 0, 0,  0,  1'b1};
    vecs[4]  = '{1, 496,   1'b0, 0, 0,  0,  1'b1};
    vecs[5]  = '{1, 497,   1'b1, 0, 0,  0,  1'b1};
    vecs[6]  = '{0, 658,   1'b0, 0, 0,  0,  1'b1};
    vecs[7]  = '{0, 659,   1'b0, 0, 0,  0,  1'b0};
    vecs[8]  = '{0, 754,   1'b0, 0, 0,  0,  1'b0};
    vecs[9]  = '{0, 755,   1'b0, 0, 0,  0,  1'b1};
    vecs[10] = '{1, 2481,  1'b0, 0, 0,  0,  1'b1};
    vecs[11] = '{1, 2554,  1'b1, 5, 1,  1,  1'b1};
    vecs[12] = '{1, 4280,  1'b1, 7, 15, 15, 1'b1};
    vecs[13] = '{1, 4341,  1'b0, 0, 0,  0,  1'b1};
    vecs[14] = '{0, 51264, 1'b0, 0, 0,  0,  1'b1};
    vecs[15] = '{0, 51265, 1'b1, 0, 0,  0,  1'b1};
    vecs[16] = '{0, 51301, 1'b1, 2, 0,  4,  1'b1};
    vecs[17] = '{0, 51777, 1'b0, 0, 0,  0,  1'b1};

    // Reset held low: outputs must sit at reset values and not advance.
    @(negedge clk);
    check_all();
    for (int i = 0; i < 5; i++) cyc(1'b1);

    @(negedge clk);
    reset = 1'b1;

    // Free run from release with en=1, probing the table points on the way.
    for (int i = 0; i < 18; i++) begin
      while (k < vecs[i].k) begin
        cyc(1'b1);
        if (s_fs) small_fs_cnt++;
      end
      exp_v = {vecs[i].it, 4'(vecs[i].ci), vecs[i].gr[3:0], vecs[i].gc[3:0], vecs[i].hs} ;
      if (vecs[i].inst == 0) got_v = {f_it, f_ci[3:0], f_gr, f_gc, f_hs};
      else                   got_v = {s_it, s_ci[3:0], s_gr, s_gc, s_hs};
      n_checks++;
      if (got_v !== exp_v || (vecs[i].inst == 0 ? f_ci : s_ci) !== 10'(vecs[i].ci)) begin
        n_fail++;
        $display("FAIL table[%0d] k=%0d got=%h expected=%h", i, k, got_v, exp_v);
      end
    end
    while (k < 52000) begin
      cyc(1'b1);
      if (s_fs) small_fs_cnt++;
    end

    n_checks++;
    if (first_fall != 659) begin
      n_fail++;
      $display("FAIL first_hsync_fall got=%0d expected=659", first_fall);
    end
    // Small frame is 5640 cycles; states 5640*m for m=1..9 fall in the run.
    n_checks++;
    if (small_fs_cnt != 9) begin
      n_fail++;
      $display("FAIL small_frame_start_count got=%0d expected=9", small_fs_cnt);
    end
`ifdef VGA_TEXT_BLINK_EN
    blink_exp = 32 * 264 + 1;
`else
    blink_exp = -1;
`endif
    n_checks++;
    if (blink_rise != blink_exp) begin
      n_fail++;
      $display("FAIL tiny_blink_rise got=%0d expected=%0d", blink_rise, blink_exp);
    end

    // Alternating enable: outputs must hold on every en=0 cycle.
    for (int i = 0; i < 3000; i++) cyc(i[0] == 1'b0);
    // Random enable pattern.
    for (int i = 0; i < 4000; i++) cyc(($urandom % 4) != 0);

    // Asynchronous reset mid-frame, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    k = 0;
    check_all();
    for (int i = 0; i < 3; i++) cyc(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 1500; i++) cyc(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
